// File: rtl/inv_issue_sched.sv
// Issue scheduler for a pipelined masked GF(2^4) inverter shared by two requesters.
// Round-robin on contention, gated by fresh-mask availability; results are routed back by id.
module inv_issue_sched #(
  parameter int SHARES  = 2,
  parameter int LATENCY = 2
) (
  input  logic                  ClkxCI,
  input  logic                  RstxBI,
  input  logic                  Req0ValidxSI,
  input  logic                  Req1ValidxSI,
  input  logic [4*SHARES-1:0]   Req0DataxDI,
  input  logic [4*SHARES-1:0]   Req1DataxDI,
  output logic                  Req0ReadyxSO,
  output logic                  Req1ReadyxSO,
  input  logic                  RndValidxSI,
  output logic                  RndReadyxSO,
  output logic [4*SHARES-1:0]   InvXxDO,
  input  logic [4*SHARES-1:0]   InvQxDI,
  output logic                  Resp0ValidxSO,
  output logic                  Resp1ValidxSO,
  output logic [4*SHARES-1:0]   Resp0DataxDO,
  output logic [4*SHARES-1:0]   Resp1DataxDO,
  output logic                  BusyxSO,
  output logic [15:0]           IssueCntxDO
);

  localparam int W = 4 * SHARES;

  logic               prio_q, prio_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [LATENCY-1:0] id_q, id_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               issue_s, grant_s, both_s;

  // Arbitration, operand routing and next-state of the in-flight pipeline.
  // Issue is gated by reset so no handshake can complete while the block is held.
  always_comb begin
    both_s  = Req0ValidxSI & Req1ValidxSI;
    issue_s = (Req0ValidxSI | Req1ValidxSI) & RndValidxSI & RstxBI;
    if (both_s) begin
      grant_s = prio_q;
    end else if (Req1ValidxSI) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end

    prio_d = prio_q;
    if (issue_s && both_s) begin
      prio_d = ~prio_q;
    end else begin
      prio_d = prio_q;
    end

    if (issue_s) begin
      InvXxDO = grant_s ? Req1DataxDI : Req0DataxDI;
      cnt_d   = cnt_q + 16'd1;
    end else begin
      InvXxDO = {W{1'b0}};
      cnt_d   = cnt_q;
    end

    vld_d    = vld_q;
    id_d     = id_q;
    vld_d[0] = issue_s;
    id_d[0]  = grant_s;
    for (int k = 1; k < LATENCY; k++) begin
      vld_d[k] = vld_q[k-1];
      id_d[k]  = id_q[k-1];
    end
  end

  // Handshakes and result demux; results from the inverter are passed straight through.
  always_comb begin
    Req0ReadyxSO  = issue_s & ~grant_s;
    Req1ReadyxSO  = issue_s &  grant_s;
    RndReadyxSO   = issue_s;
    Resp0ValidxSO = vld_q[LATENCY-1] & ~id_q[LATENCY-1];
    Resp1ValidxSO = vld_q[LATENCY-1] &  id_q[LATENCY-1];
    Resp0DataxDO  = Resp0ValidxSO ? InvQxDI : {W{1'b0}};
    Resp1DataxDO  = Resp1ValidxSO ? InvQxDI : {W{1'b0}};
    BusyxSO       = |vld_q;
    IssueCntxDO   = cnt_q;
  end

  // State registers; reset drops every in-flight operation.
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      prio_q <= 1'b0;
      vld_q  <= {LATENCY{1'b0}};
      id_q   <= {LATENCY{1'b0}};
      cnt_q  <= 16'd0;
    end else begin
      prio_q <= prio_d;
      vld_q  <= vld_d;
      id_q   <= id_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_inv_issue_sched.sv
// Bench for inv_issue_sched: three instances (LATENCY 1, 2, 8) share stimulus and are
// compared every cycle against a cycle-indexed issue log, plus per-scenario checks.
module tb_inv_issue_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       v0 = 1'b0, v1 = 1'b0, rv = 1'b0;
  logic [7:0] d0 = 8'h00, d1 = 8'h00, invq = 8'h00;
  logic [2:0] r0, r1, rr, busy, p0v, p1v;
  logic [7:0] invx [3];
  logic [7:0] p0d  [3];
  logic [7:0] p1d  [3];
  logic [15:0] cnt [3];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 2 : 8);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    inv_issue_sched #(.SHARES(2), .LATENCY((g == 0) ? 1 : ((g == 1) ? 2 : 8))) u_dut (
      .ClkxCI(clk), .RstxBI(rst_n),
      .Req0ValidxSI(v0), .Req1ValidxSI(v1),
      .Req0DataxDI(d0), .Req1DataxDI(d1),
      .Req0ReadyxSO(r0[g]), .Req1ReadyxSO(r1[g]),
      .RndValidxSI(rv), .RndReadyxSO(rr[g]),
      .InvXxDO(invx[g]), .InvQxDI(invq),
      .Resp0ValidxSO(p0v[g]), .Resp1ValidxSO(p1v[g]),
      .Resp0DataxDO(p0d[g]), .Resp1DataxDO(p1d[g]),
      .BusyxSO(busy[g]), .IssueCntxDO(cnt[g])
    );
  end

  // Reference model: per-cycle log of which requester issued, with an epoch marking the last reset.
  int cyc = 0;
  int epoch = 0;
  int m_cnt = 0;
  bit m_prio = 1'b0;
  int log_id [int];

  always @(negedge clk) begin
    bit issue, gnt, ev0, ev1, eb;
    int c, lat;
    logic [7:0] ex;
    logic [5:0] ctl_exp, ctl_got;
    logic [39:0] dat_exp, dat_got;
    if (!rst_n) begin
      m_prio = 1'b0;
      m_cnt  = 0;
      epoch  = cyc + 1;
      for (int g = 0; g < 3; g++) begin
        total++;
        ctl_got = {r0[g], r1[g], rr[g], busy[g], p0v[g], p1v[g]};
        if (ctl_got !== 6'd0 || cnt[g] !== 16'd0)
          $display("FAIL mon_reset lat=%0d ctl=%b cnt=%h expected ctl=000000 cnt=0000", lat_of(g), ctl_got, cnt[g]);
        else passed++;
      end
    end else begin
      issue = (v0 || v1) && rv;
      gnt   = (v0 && v1) ? m_prio : v1;
      ex    = issue ? (gnt ? d1 : d0) : 8'h00;
      for (int g = 0; g < 3; g++) begin
        lat = lat_of(g);
        c   = cyc - lat;
        ev0 = (c >= epoch) && log_id.exists(c) && (log_id[c] == 0);
        ev1 = (c >= epoch) && log_id.exists(c) && (log_id[c] == 1);
        eb  = 1'b0;
        for (int k = 1; k <= lat; k++)
          if ((cyc - k) >= epoch && log_id.exists(cyc - k)) eb = 1'b1;
        ctl_exp = {issue && !gnt, issue && gnt, issue, eb, ev0, ev1};
        ctl_got = {r0[g], r1[g], rr[g], busy[g], p0v[g], p1v[g]};
        dat_exp = {ex, ev0 ? invq : 8'h00, ev1 ? invq : 8'h00, m_cnt[15:0]};
        dat_got = {invx[g], p0d[g], p1d[g], cnt[g]};
        total++;
        if (ctl_got !== ctl_exp)
          $display("FAIL mon_ctl lat=%0d cyc=%0d got r0,r1,rnd,busy,p0v,p1v=%b expected %b", lat, cyc, ctl_got, ctl_exp);
        else passed++;
        total++;
        if (dat_got !== dat_exp)
          $display("FAIL mon_data lat=%0d cyc=%0d got invx,p0d,p1d,cnt=%h expected %h", lat, cyc, dat_got, dat_exp);
        else passed++;
      end
      if (issue) begin
        log_id[cyc] = gnt ? 1 : 0;
        m_cnt = (m_cnt + 1) % 65536;
        if (v0 && v1) m_prio = !m_prio;
      end
    end
    cyc++;
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    v0 = 1'b0; v1 = 1'b0; rv = 1'b0; d0 = 8'h00; d1 = 8'h00;
  endtask

  task automatic do_reset();
    idle();
    @(posedge clk);
    #1 rst_n = 1'b0;
    adv();
    adv();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    v0 = 1'b1; v1 = 1'b1; rv = 1'b1;
    mid();
    total++;
    if ({r0[1], r1[1], rr[1], busy[1], p0v[1], p1v[1]} !== 6'd0 || cnt[1] !== 16'd0)
      $display("FAIL reset_outputs got ready/busy/resp=%b cnt=%h expected 0", {r0[1], r1[1], rr[1], busy[1], p0v[1], p1v[1]}, cnt[1]);
    else passed++;
    adv();
    rst_n = 1'b1; v1 = 1'b0;
    mid();
    total++;
    if (r0[1] !== 1'b1) $display("FAIL reset_first_issue got ready0=%b expected 1", r0[1]);
    else passed++;
    adv();
    idle();
    mid();
    total++;
    if (cnt[1] !== 16'd1) $display("FAIL reset_first_count got %0d expected 1", cnt[1]);
    else passed++;
    adv();
  endtask

  task automatic test_single();
    logic [7:0] q;
    do_reset();
    v0 = 1'b1; d0 = 8'h5A; rv = 1'b1;
    mid();
    total++;
    if ({r0[1], r1[1], rr[1]} !== 3'b101 || invx[1] !== 8'h5A)
      $display("FAIL single_issue got r0,r1,rnd=%b invx=%h expected 101 5a", {r0[1], r1[1], rr[1]}, invx[1]);
    else passed++;
    adv();
    idle();
    mid();
    total++;
    if (p0v[1] !== 1'b0) $display("FAIL single_early got resp0v=%b expected 0", p0v[1]);
    else passed++;
    adv();
    q = 8'($urandom);
    invq = q;
    mid();
    total++;
    if (p0v[1] !== 1'b1 || p0d[1] !== q || p1v[1] !== 1'b0)
      $display("FAIL single_resp got v0=%b d0=%h v1=%b expected 1 %h 0", p0v[1], p0d[1], p1v[1], q);
    else passed++;
    adv();
    mid();
    total++;
    if (p0v[1] !== 1'b0 || p0d[1] !== 8'h00)
      $display("FAIL single_late got v0=%b d0=%h expected 0 00", p0v[1], p0d[1]);
    else passed++;
    adv();
  endtask

  task automatic test_contention();
    do_reset();
    v0 = 1'b1; v1 = 1'b1; rv = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d0 = 8'($urandom); d1 = 8'($urandom); invq = 8'($urandom);
      mid();
      total++;
      if (r0[1] !== (i % 2 == 0) || r1[1] !== (i % 2 == 1))
        $display("FAIL contention_grant i=%0d got r0=%b r1=%b expected grant %0d", i, r0[1], r1[1], i % 2);
      else passed++;
      if (i >= 2) begin
        total++;
        if (p0v[1] !== (i % 2 == 0) || p1v[1] !== (i % 2 == 1))
          $display("FAIL contention_resp i=%0d got p0v=%b p1v=%b expected id %0d", i, p0v[1], p1v[1], i % 2);
        else passed++;
      end
      if (i == 4) begin
        total++;
        if (cnt[1] !== 16'd4) $display("FAIL contention_count got %0d expected 4", cnt[1]);
        else passed++;
      end
      adv();
    end
    idle();
  endtask

  task automatic test_starvation();
    do_reset();
    v0 = 1'b1; v1 = 1'b1; rv = 1'b1; d0 = 8'h11; d1 = 8'h22;
    adv();
    rv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      total++;
      if ({r0[1], r1[1], rr[1]} !== 3'b000 || invx[1] !== 8'h00)
        $display("FAIL starve_idle i=%0d got r0,r1,rnd=%b invx=%h expected 000 00", i, {r0[1], r1[1], rr[1]}, invx[1]);
      else passed++;
      adv();
    end
    rv = 1'b1;
    mid();
    total++;
    if (r1[1] !== 1'b1 || r0[1] !== 1'b0 || invx[1] !== 8'h22)
      $display("FAIL starve_resume got r0=%b r1=%b invx=%h expected 0 1 22", r0[1], r1[1], invx[1]);
    else passed++;
    adv();
    mid();
    total++;
    if (r0[1] !== 1'b1) $display("FAIL starve_next got r0=%b expected 1", r0[1]);
    else passed++;
    adv();
    idle();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    v0 = 1'b1; rv = 1'b1;
    adv();
    v0 = 1'b0; v1 = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    idle();
    adv();
    adv();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mid();
      total++;
      if ({p0v, p1v, busy} !== 9'd0 || cnt[1] !== 16'd0 || cnt[2] !== 16'd0)
        $display("FAIL midflight i=%0d got resp/busy=%b cnt=%h expected 0 0000", i, {p0v, p1v, busy}, cnt[1]);
      else passed++;
      adv();
    end
  endtask

  task automatic test_random();
    int n_issue = 0;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      v0 = 1'($urandom); v1 = 1'($urandom); rv = ($urandom_range(3, 0) != 0);
      d0 = 8'($urandom); d1 = 8'($urandom); invq = 8'($urandom);
      if ((v0 || v1) && rv) n_issue++;
      adv();
    end
    idle();
    mid();
    total++;
    if (cnt[1] !== 16'(n_issue)) $display("FAIL random_count got %0d expected %0d", cnt[1], n_issue);
    else passed++;
    adv();
  endtask

  task automatic test_latency_sweep();
    do_reset();
    v1 = 1'b1; rv = 1'b1; d1 = 8'($urandom);
    adv();
    idle();
    for (int k = 1; k <= 9; k++) begin
      invq = 8'($urandom);
      mid();
      total++;
      if (p1v[0] !== (k == 1) || p1v[2] !== (k == 8) || p0v[0] !== 1'b0 || p0v[2] !== 1'b0 ||
          p1d[0] !== ((k == 1) ? invq : 8'h00) || p1d[2] !== ((k == 8) ? invq : 8'h00))
        $display("FAIL sweep k=%0d got l1 v=%b d=%h l8 v=%b d=%h invq=%h", k, p1v[0], p1d[0], p1v[2], p1d[2], invq);
      else passed++;
      adv();
    end
  endtask

  task automatic test_wrap();
    do_reset();
    v0 = 1'b1; rv = 1'b1;
    repeat (65536) begin
      d0 = 8'($urandom); invq = 8'($urandom);
      adv();
    end
    mid();
    total++;
    if (cnt[1] !== 16'h0000 || r0[1] !== 1'b1)
      $display("FAIL wrap_zero got cnt=%h ready0=%b expected 0000 1", cnt[1], r0[1]);
    else passed++;
    adv();
    idle();
    mid();
    total++;
    if (cnt[1] !== 16'h0001) $display("FAIL wrap_continue got cnt=%h expected 0001", cnt[1]);
    else passed++;
    adv();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_starvation();
    test_reset_midflight();
    test_random();
    test_latency_sweep();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
